// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C initiator. One START / address / data / STOP
// sequence per accepted request; SCL and SDA are driven as open-drain enables.
// Define I2C_MASTER_READ_EN to honour rw and build the read path; otherwise
// every transaction is a write and rd_data is tied to zero.
module i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam logic [11:0] QMAX = 12'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
        S_RDATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    state_t      state_reg;
    logic [11:0] qcnt_reg;
    logic [1:0]  ph_reg;
    logic [2:0]  bcnt_reg;
    logic [7:0]  sh_reg;
    logic [7:0]  wdata_reg;
    logic        rw_reg;
    logic        samp_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        ack_err_reg;
    logic        scl_oe_reg;
    logic        sda_oe_reg;
    logic        rw_in;
    logic        tick;
    logic        bit_end;
    logic        active;
    logic        scl_drv;
    logic        sda_drv;

`ifdef I2C_MASTER_READ_EN
    logic [7:0] rx_reg;
    logic [7:0] rd_data_reg;
    assign rw_in   = rw;
    assign rd_data = rd_data_reg;
`else
    // Write-only build: the R/W bit is always 0 and rw is deliberately ignored.
    logic unused_rw;
    assign unused_rw = rw;
    assign rw_in     = 1'b0;
    assign rd_data   = 8'h00;
`endif

    assign tick    = (qcnt_reg == QMAX);
    assign bit_end = tick && (ph_reg == 2'd3);
    assign active  = (state_reg != S_IDLE) && (state_reg != S_DONE);

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ack_err = ack_err_reg;
    assign scl_oe  = scl_oe_reg;
    assign sda_oe  = sda_oe_reg;

    // Line levels implied by the current state and quarter; registered below.
    always_comb begin
        scl_drv = 1'b0;
        sda_drv = 1'b0;
        case (state_reg)
            S_START: sda_drv = ph_reg[1];
            S_ADDR, S_WDATA: begin
                scl_drv = ~ph_reg[1];
                sda_drv = ~sh_reg[7];
            end
            S_ADDR_ACK, S_RDATA, S_DATA_ACK: scl_drv = ~ph_reg[1];
            S_STOP: begin
                scl_drv = (ph_reg == 2'd0);
                sda_drv = (ph_reg != 2'd3);
            end
            default: ;
        endcase
    end

    // Transaction FSM, quarter timing, bit shifting and registered pin enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            qcnt_reg    <= '0;
            ph_reg      <= '0;
            bcnt_reg    <= '0;
            sh_reg      <= '0;
            wdata_reg   <= '0;
            rw_reg      <= 1'b0;
            samp_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ack_err_reg <= 1'b0;
            scl_oe_reg  <= 1'b0;
            sda_oe_reg  <= 1'b0;
`ifdef I2C_MASTER_READ_EN
            rx_reg      <= '0;
            rd_data_reg <= '0;
`endif
        end else begin
            scl_oe_reg <= scl_drv;
            sda_oe_reg <= sda_drv;
            done_reg   <= 1'b0;

            if (!active || tick) qcnt_reg <= '0;
            else                 qcnt_reg <= qcnt_reg + 12'd1;

            if (active && tick) ph_reg <= ph_reg + 2'd1;

            // SDA is sampled on the tick that ends ph2, while SCL is high.
            if (active && tick && ph_reg == 2'd2) samp_reg <= sda_i;
`ifdef I2C_MASTER_READ_EN
            if (state_reg == S_RDATA && tick && ph_reg == 2'd2)
                rx_reg <= {rx_reg[6:0], sda_i};
`endif

            case (state_reg)
                S_IDLE: if (start) begin
                    busy_reg    <= 1'b1;
                    ack_err_reg <= 1'b0;
                    sh_reg      <= {addr, rw_in};
                    rw_reg      <= rw_in;
                    wdata_reg   <= wr_data;
                    ph_reg      <= '0;
                    state_reg   <= S_START;
                end
                S_START: if (bit_end) begin
                    bcnt_reg  <= '0;
                    state_reg <= S_ADDR;
                end
                S_ADDR: if (bit_end) begin
                    if (bcnt_reg == 3'd7) state_reg <= S_ADDR_ACK;
                    else begin
                        bcnt_reg <= bcnt_reg + 3'd1;
                        sh_reg   <= {sh_reg[6:0], 1'b0};
                    end
                end
                S_ADDR_ACK: if (bit_end) begin
                    bcnt_reg <= '0;
                    if (samp_reg) begin
                        ack_err_reg <= 1'b1;
                        state_reg   <= S_STOP;
`ifdef I2C_MASTER_READ_EN
                    end else if (rw_reg) begin
                        state_reg <= S_RDATA;
`endif
                    end else begin
                        sh_reg    <= wdata_reg;
                        state_reg <= S_WDATA;
                    end
                end
                S_WDATA: if (bit_end) begin
                    if (bcnt_reg == 3'd7) state_reg <= S_DATA_ACK;
                    else begin
                        bcnt_reg <= bcnt_reg + 3'd1;
                        sh_reg   <= {sh_reg[6:0], 1'b0};
                    end
                end
`ifdef I2C_MASTER_READ_EN
                S_RDATA: if (bit_end) begin
                    if (bcnt_reg == 3'd7) state_reg <= S_DATA_ACK;
                    else                  bcnt_reg  <= bcnt_reg + 3'd1;
                end
`endif
                S_DATA_ACK: if (bit_end) begin
                    // On a read the master leaves SDA released (NACK), so only
                    // a write can report a data-phase acknowledge error.
                    if (!rw_reg && samp_reg) ack_err_reg <= 1'b1;
`ifdef I2C_MASTER_READ_EN
                    if (rw_reg) rd_data_reg <= rx_reg;
`endif
                    state_reg <= S_STOP;
                end
                S_STOP: if (bit_end) state_reg <= S_DONE;
                S_DONE: begin
                    if (!done_reg) done_reg <= 1'b1;
                    else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule
